jt12_ch_wr_ctl: RTL and testbench

Host-side write sequencer for the channel register file. It decodes CPU address/data port writes to the channel registers (A0–A6, B0–B6) and queues them in a small FIFO. It then replays the queued writes as single-clock update strobes (up_fnumlo/up_alg/up_pms) with stable up_ch/dout/latch_fnum, and models chip busy time between writes. It sits between the CPU bus interface and the channel register file, beside the operator CSR write path.

---
 rtl/jt12_ch_wr_ctl.sv | 192 +++++++++++++++++++
 tb/tb_jt12_ch_wr_ctl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_ch_wr_ctl.sv
// Channel register write sequencer: decodes CPU address/data writes, queues them,
// and replays each as a single-clock update strobe followed by a busy hold period.
module jt12_ch_wr_ctl #(
  parameter int NUM_CH     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_CYC   = 8
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       cpu_we,
  input  logic [1:0] cpu_a,
  input  logic [7:0] cpu_din,
  output logic       busy,
  output logic       ovf,
  output logic [7:0] dout,
  output logic [2:0] up_ch,
  output logic [5:0] latch_fnum,
  output logic       up_fnumlo,
  output logic       up_alg,
  output logic       up_pms
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(BUSY_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]        addr_lat_q, addr_lat_d;
  logic              part_lat_q, part_lat_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        dout_q, dout_d;
  logic [2:0]        up_ch_q, up_ch_d;
  logic [5:0]        latch_fnum_q, latch_fnum_d;
  logic              up_fnumlo_q, up_fnumlo_d;
  logic              up_alg_q, up_alg_d;
  logic              up_pms_q, up_pms_d;

  // Entry layout: {part, addr[7:0], data[7:0]}
  logic [16:0] fifo_mem_q [FIFO_DEPTH];
  logic [16:0] fifo_mem_d [FIFO_DEPTH];

  logic        push_req, push_ok, pop, full;
  logic [16:0] head;
  logic        head_part;
  logic [7:0]  head_addr, head_data;
  logic [1:0]  ch_sel;
  logic        target_ok;
  logic [2:0]  ch_idx;

  assign head      = fifo_mem_q[rd_ptr_q];
  assign head_part = head[16];
  assign head_addr = head[15:8];
  assign head_data = head[7:0];
  assign ch_sel    = head_addr[1:0];
  assign target_ok = (ch_sel != 2'd3) && ((NUM_CH == 6) || !head_part);
  assign ch_idx    = (NUM_CH == 6) ? {head_part, ch_sel} : {1'b0, ch_sel};

  assign full     = (count_q == FULL_CNT);
  assign pop      = (state_q == S_IDLE) && cen && (count_q != '0);
  assign push_req = cpu_we && cpu_a[0];
  // A pop in the same clk frees a slot, so a push into a full queue still lands
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    addr_lat_d   = addr_lat_q;
    part_lat_d   = part_lat_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    ovf_d        = ovf_q;
    dout_d       = dout_q;
    up_ch_d      = up_ch_q;
    latch_fnum_d = latch_fnum_q;
    up_fnumlo_d  = 1'b0;
    up_alg_d     = 1'b0;
    up_pms_d     = 1'b0;
    fifo_mem_d   = fifo_mem_q;

    if (cpu_we && !cpu_a[0]) begin
      addr_lat_d = cpu_din;
      part_lat_d = cpu_a[1];
    end

    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = {part_lat_q, addr_lat_q, cpu_din};
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else if (push_req) begin
      ovf_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_STROBE;
          dout_d  = head_data;
          up_ch_d = ch_idx;
          if (target_ok) begin
            case (head_addr[7:2])
              6'h28:   up_fnumlo_d  = 1'b1;
              6'h29:   latch_fnum_d = head_data[5:0];
              6'h2C:   up_alg_d     = 1'b1;
              6'h2D:   up_pms_d     = 1'b1;
              default: ;
            endcase
          end
        end
      end
      S_STROBE: begin
        state_d    = S_HOLD;
        hold_cnt_d = HOLD_LOAD;
      end
      S_HOLD: begin
        if (cen) begin
          if (hold_cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      addr_lat_q   <= '0;
      part_lat_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      dout_q       <= '0;
      up_ch_q      <= '0;
      latch_fnum_q <= '0;
      up_fnumlo_q  <= 1'b0;
      up_alg_q     <= 1'b0;
      up_pms_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      addr_lat_q   <= addr_lat_d;
      part_lat_q   <= part_lat_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      dout_q       <= dout_d;
      up_ch_q      <= up_ch_d;
      latch_fnum_q <= latch_fnum_d;
      up_fnumlo_q  <= up_fnumlo_d;
      up_alg_q     <= up_alg_d;
      up_pms_q     <= up_pms_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign busy       = (count_q != '0) | (state_q != S_IDLE);
  assign ovf        = ovf_q;
  assign dout       = dout_q;
  assign up_ch      = up_ch_q;
  assign latch_fnum = latch_fnum_q;
  assign up_fnumlo  = up_fnumlo_q;
  assign up_alg     = up_alg_q;
  assign up_pms     = up_pms_q;

endmodule

// File: tb/tb_jt12_ch_wr_ctl.sv
// Randomized self-checking bench for jt12_ch_wr_ctl, run against a queue-based
// reference model; one DUT per channel-count configuration shares the stimulus.
module tb_jt12_ch_wr_ctl;

   localparam int FIFO_DEPTH = 4;
   localparam int BUSY_CYC   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       cen;
   logic       cpuWe;
   logic [1:0] cpuA;
   logic [7:0] cpuDin;

   logic       busy6, ovf6, fnum6, alg6, pms6;
   logic [7:0] dout6;
   logic [2:0] upCh6;
   logic [5:0] latch6;
   logic       busy3, ovf3, fnum3, alg3, pms3;
   logic [7:0] dout3;
   logic [2:0] upCh3;
   logic [5:0] latch3;

   always #5 clk = ~clk;

   jt12_ch_wr_ctl #(.NUM_CH(6), .FIFO_DEPTH(FIFO_DEPTH), .BUSY_CYC(BUSY_CYC)) dut6 (
      .rst(rst), .clk(clk), .cen(cen), .cpu_we(cpuWe), .cpu_a(cpuA), .cpu_din(cpuDin),
      .busy(busy6), .ovf(ovf6), .dout(dout6), .up_ch(upCh6), .latch_fnum(latch6),
      .up_fnumlo(fnum6), .up_alg(alg6), .up_pms(pms6)
   );

   jt12_ch_wr_ctl #(.NUM_CH(3), .FIFO_DEPTH(FIFO_DEPTH), .BUSY_CYC(BUSY_CYC)) dut3 (
      .rst(rst), .clk(clk), .cen(cen), .cpu_we(cpuWe), .cpu_a(cpuA), .cpu_din(cpuDin),
      .busy(busy3), .ovf(ovf3), .dout(dout3), .up_ch(upCh3), .latch_fnum(latch3),
      .up_fnumlo(fnum3), .up_alg(alg3), .up_pms(pms3)
   );

   typedef struct packed {
      logic       part;
      logic [7:0] addr;
      logic [7:0] data;
   } entry_t;

   int checkCount = 0;
   int passCount  = 0;

   // Reference model: pending writes, recovery ticks still owed, expected outputs
   entry_t     mq[$];
   logic [7:0] mAddr;
   logic       mPart;
   logic       mOvf;
   bit         mStrobeNext;
   int         mGap;
   logic [7:0] eDout;
   int         eCh6, eCh3;
   logic [5:0] eLatch6, eLatch3;
   int         eKind6, eKind3;

   // Kinds: 0 nothing, 1 fnum low commit, 2 fnum high latch, 3 alg commit, 4 pms commit
   function automatic int decodeKind(input int numCh, input logic part, input logic [7:0] addr);
      if (addr % 4 == 3) return 0;
      if (numCh == 3 && part) return 0;
      if (addr >= 8'hA0 && addr <= 8'hA2) return 1;
      if (addr >= 8'hA4 && addr <= 8'hA6) return 2;
      if (addr >= 8'hB0 && addr <= 8'hB2) return 3;
      if (addr >= 8'hB4 && addr <= 8'hB6) return 4;
      return 0;
   endfunction

   task automatic modelReset();
      mq.delete();
      mAddr = 8'h00; mPart = 1'b0; mOvf = 1'b0;
      mStrobeNext = 0; mGap = 0;
      eDout = 8'h00; eCh6 = 0; eCh3 = 0;
      eLatch6 = 6'h00; eLatch3 = 6'h00;
      eKind6 = 0; eKind3 = 0;
   endtask

   // Advance the model across one rising edge with the given inputs applied
   task automatic modelEdge(input logic we, input logic [1:0] a, input logic [7:0] din, input logic cenIn);
      bit popNow;
      entry_t e;
      int k6, k3;
      popNow = cenIn && (mq.size() > 0) && !mStrobeNext && (mGap == 0);
      if (mStrobeNext) begin
         mGap = BUSY_CYC;
         mStrobeNext = 0;
      end else if (cenIn && mGap > 0) begin
         mGap--;
      end
      eKind6 = 0;
      eKind3 = 0;
      if (popNow) begin
         e = mq.pop_front();
         eDout = e.data;
         eCh6 = int'(e.part) * 4 + int'(e.addr % 4);
         eCh3 = int'(e.addr % 4);
         k6 = decodeKind(6, e.part, e.addr);
         k3 = decodeKind(3, e.part, e.addr);
         if (k6 == 2) eLatch6 = e.data[5:0]; else eKind6 = k6;
         if (k3 == 2) eLatch3 = e.data[5:0]; else eKind3 = k3;
         mStrobeNext = 1;
      end
      if (we && a[0]) begin
         if (mq.size() < FIFO_DEPTH) mq.push_back('{mPart, mAddr, din});
         else mOvf = 1'b1;
      end
      if (we && !a[0]) begin
         mAddr = din;
         mPart = a[1];
      end
   endtask

   function automatic bit modelBusy();
      return (mq.size() != 0) || mStrobeNext || (mGap > 0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      else passCount++;
   endtask

   task automatic checkAll();
      checkOutput("busy6", busy6, modelBusy());
      checkOutput("busy3", busy3, modelBusy());
      checkOutput("ovf6", ovf6, mOvf);
      checkOutput("ovf3", ovf3, mOvf);
      checkOutput("dout6", dout6, eDout);
      checkOutput("dout3", dout3, eDout);
      checkOutput("up_ch6", upCh6, eCh6);
      checkOutput("up_ch3", upCh3, eCh3);
      checkOutput("latch_fnum6", latch6, eLatch6);
      checkOutput("latch_fnum3", latch3, eLatch3);
      checkOutput("up_fnumlo6", fnum6, eKind6 == 1);
      checkOutput("up_alg6", alg6, eKind6 == 3);
      checkOutput("up_pms6", pms6, eKind6 == 4);
      checkOutput("up_fnumlo3", fnum3, eKind3 == 1);
      checkOutput("up_alg3", alg3, eKind3 == 3);
      checkOutput("up_pms3", pms3, eKind3 == 4);
   endtask

   // One clk: check at the falling edge, drive inputs, step the model, advance
   task automatic applyStimulus(input logic we, input logic [1:0] a, input logic [7:0] din, input logic cenIn);
      checkAll();
      cpuWe = we; cpuA = a; cpuDin = din; cen = cenIn;
      modelEdge(we, a, din, cenIn);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic writeReg(input logic part, input logic [7:0] addr, input logic [7:0] data, input logic cenIn);
      applyStimulus(1'b1, {part, 1'b0}, addr, cenIn);
      applyStimulus(1'b1, {part, 1'b1}, data, cenIn);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && modelBusy(); i++) applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      checkOutput("drain_busy6", busy6, 1'b0);
   endtask

   logic [7:0] addrTable [16];

   initial begin
      addrTable = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hB0,
                    8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'h30, 8'h28};
      rst = 1'b1; cen = 1'b0; cpuWe = 1'b0; cpuA = 2'b00; cpuDin = 8'h00;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkAll();
      rst = 1'b0;

      // Full queue with a pop and a push on the same clk
      applyStimulus(1'b1, 2'b00, 8'hA1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 8'h10 + 8'(i), 1'b0);
      applyStimulus(1'b1, 2'b01, 8'h77, 1'b1);
      checkOutput("samecyc_ovf6", ovf6, 1'b0);
      drain();

      // Directed channel targets, including invalid ones
      writeReg(1'b1, 8'hA4, 8'h2B, 1'b1);
      writeReg(1'b1, 8'hA0, 8'h55, 1'b1);
      writeReg(1'b0, 8'hB4, 8'hC7, 1'b1);
      writeReg(1'b1, 8'hB2, 8'h3A, 1'b1);
      writeReg(1'b0, 8'hA3, 8'h11, 1'b1);
      writeReg(1'b0, 8'hB3, 8'h22, 1'b1);
      writeReg(1'b0, 8'h30, 8'h33, 1'b1);
      writeReg(1'b1, 8'hB0, 8'h44, 1'b1);
      drain();

      // Overflow: five data writes with the sequencer stalled
      applyStimulus(1'b1, 2'b00, 8'hA2, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 8'h60 + 8'(i), 1'b0);
      checkOutput("burst_ovf6", ovf6, 1'b1);
      drain();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic       we;
         logic [1:0] a;
         logic [7:0] d;
         we = ($urandom % 100) < 45;
         a  = 2'($urandom);
         d  = a[0] ? 8'($urandom) : addrTable[$urandom % 16];
         applyStimulus(we, a, d, ($urandom % 100) < 60);
      end
      drain();

      // Reset while holding with entries still queued
      writeReg(1'b0, 8'hA4, 8'h15, 1'b1);
      applyStimulus(1'b1, 2'b00, 8'hA0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 8'h80 + 8'(i), 1'b1);
      for (int i = 0; i < 50 && !(mGap > 0 && mq.size() == 3); i++)
         applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      checkOutput("hold_with_3_queued", (mGap > 0 && mq.size() == 3), 1'b1);
      cpuWe = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rst_busy6", busy6, 1'b0);
      checkOutput("rst_fnum6", fnum6, 1'b0);
      checkOutput("rst_alg6", alg6, 1'b0);
      checkOutput("rst_pms6", pms6, 1'b0);
      checkOutput("rst_latch6", latch6, 6'h00);
      checkOutput("rst_busy3", busy3, 1'b0);
      modelReset();
      @(posedge clk);
      @(negedge clk);
      checkAll();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      checkAll();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
